// File: rtl/button_debounce_reader_pkg.sv
// -----------------------------------------------------------------------------
// button_debounce_reader_pkg
//   Shared definitions for the push-button reader: FSM state encoding and the
//   12 MHz-derived cycle counts used as parameter defaults.
//   No ports (package).
// -----------------------------------------------------------------------------
package button_debounce_reader_pkg;

  // Board clock the default cycle counts are derived from.
  localparam int CLK_HZ = 12_000_000;

  // 10 ms of stable input before a new level is accepted.
  localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;

  // 1 s of debounced hold before a long-press is reported.
  localparam int DEFAULT_LONG_CYCLES = CLK_HZ;

  // Press-tracking FSM. Encoding 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // released
    ST_DOWN = 2'd1,  // pressed, timing towards long-press
    ST_HELD = 2'd2   // pressed, long-press already reported
  } btn_state_e;

endpackage

// File: rtl/btn_sync_debounce.sv
// -----------------------------------------------------------------------------
// btn_sync_debounce
//   Two-flop synchroniser plus stability counter for a raw button pin.
//   The debounced level only changes after the synchronised input has
//   disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any single
//   agreeing cycle restarts the count.
//
// Ports
//   clk        in   system clock, posedge
//   rst_n      in   asynchronous active-low reset
//   btn_in     in   raw asynchronous button pin
//   btn_level  out  registered debounced level, 1 = pressed
//   rise_stb   out  combinational: btn_level goes 0->1 at the next edge
//   fall_stb   out  combinational: btn_level goes 1->0 at the next edge
// -----------------------------------------------------------------------------
module btn_sync_debounce
  import button_debounce_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_q, level_d;
  logic            pressed_s;
  logic            mismatch;
  logic            accept;

  always_comb begin
    // NOTE: every signal driven here gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    sync1_d  = btn_in;
    sync2_d  = sync1_q;
    db_cnt_d = '0;
    level_d  = level_q;

    pressed_s = sync2_q ^ BTN_ACTIVE_LOW;
    mismatch  = (pressed_s != level_q);
    accept    = mismatch && (db_cnt_q == DB_LAST);

    if (accept) begin
      level_d = ~level_q;
    end else if (mismatch) begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end

    // Strobes announce the toggle one edge early so the top can register
    // its event pulses on the very edge that updates the level.
    rise_stb = accept & ~level_q;
    fall_stb = accept &  level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Synchroniser resets to the pin's idle (released) level.
      sync1_q  <= BTN_ACTIVE_LOW;
      sync2_q  <= BTN_ACTIVE_LOW;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // blocking here would collapse the two synchroniser stages into one.
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
    end
  end

  assign btn_level = level_q;

endmodule

// File: rtl/button_debounce_reader.sv
// -----------------------------------------------------------------------------
// button_debounce_reader
//   Reads a mechanical push-button, debounces it and produces clean
//   single-cycle press / release / long-press events plus a wrapping count
//   of accepted presses.
//
// Ports
//   CLK_IN         in   1          system clock, posedge
//   RST_N          in   1          asynchronous active-low reset
//   BTN_IN         in   1          raw asynchronous button pin
//   BTN_LEVEL      out  1          debounced level, 1 = pressed
//   PRESS_PULSE    out  1          1-cycle pulse on debounced press
//   RELEASE_PULSE  out  1          1-cycle pulse on debounced release
//   LONG_PULSE     out  1          1-cycle pulse once a press has lasted LONG_CYCLES
//   PRESS_COUNT    out  CNT_WIDTH  accepted presses, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module button_debounce_reader
  import button_debounce_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 CLK_IN,
  input  logic                 RST_N,
  input  logic                 BTN_IN,
  output logic                 BTN_LEVEL,
  output logic                 PRESS_PULSE,
  output logic                 RELEASE_PULSE,
  output logic                 LONG_PULSE,
  output logic [CNT_WIDTH-1:0] PRESS_COUNT
);

  localparam int                HOLD_W    = $clog2(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic rise_stb;
  logic fall_stb;

  btn_state_e           state_q, state_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 long_q, long_d;

  btn_sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_debounce (
    .clk       (CLK_IN),
    .rst_n     (RST_N),
    .btn_in    (BTN_IN),
    .btn_level (BTN_LEVEL),
    .rise_stb  (rise_stb),
    .fall_stb  (fall_stb)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    count_d   = count_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rise_stb) begin
          state_d = ST_DOWN;
          press_d = 1'b1;
          count_d = count_q + CNT_WIDTH'(1);
          hold_d  = '0;
        end
      end
      ST_DOWN: begin
        // Release is tested first so it wins over a coincident long threshold.
        if (fall_stb) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          hold_d    = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_HELD;
          long_d  = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_HELD: begin
        // Hold counter stays frozen until release.
        if (fall_stb) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          hold_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      count_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      count_q   <= count_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign PRESS_PULSE   = press_q;
  assign RELEASE_PULSE = release_q;
  assign LONG_PULSE    = long_q;
  assign PRESS_COUNT   = count_q;

endmodule

// File: tb/tb_button_debounce_reader.sv
// -----------------------------------------------------------------------------
// tb_button_debounce_reader
//   Drives button waveforms into button_debounce_reader (DEBOUNCE_CYCLES=4,
//   LONG_CYCLES=20, active-low button, 8-bit count). Every event pulse the
//   stimulus should cause is queued with the cycle it must appear on; each
//   cycle the outputs are sampled 1 time unit after the rising edge and any
//   pulse is matched against the head of that queue.
// -----------------------------------------------------------------------------
module tb_button_debounce_reader;

  localparam int DB  = 4;
  localparam int LC  = 20;
  localparam int LAT = DB + 2;  // raw edge to level change / event pulse

  typedef enum int { EV_PRESS, EV_RELEASE, EV_LONG } ev_e;

  typedef struct {
    ev_e        kind;
    int         cyc;
    logic [7:0] count;
  } ev_t;

  typedef struct {
    logic btn;          // BTN_IN level for this segment
    int   cycles;       // clocks the level is held
    bit   exp_press;    // this edge produces PRESS_PULSE LAT clocks later
    bit   exp_release;  // this edge produces RELEASE_PULSE LAT clocks later
    bit   exp_long;     // LONG_PULSE follows LC clocks after the press
    logic exp_level;    // BTN_LEVEL at the end of the segment
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [7:0] exp_count = 8'd0;
  ev_t        exp_q[$];
  vec_t       vecs[9];

  always #5 clk = ~clk;

  button_debounce_reader #(
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LC),
    .BTN_ACTIVE_LOW  (1'b1),
    .CNT_WIDTH       (8)
  ) dut (
    .CLK_IN        (clk),
    .RST_N         (rst_n),
    .BTN_IN        (btn_in),
    .BTN_LEVEL     (btn_level),
    .PRESS_PULSE   (press_pulse),
    .RELEASE_PULSE (release_pulse),
    .LONG_PULSE    (long_pulse),
    .PRESS_COUNT   (press_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_e kind, input int at);
    ev_t e;
    if (kind == EV_PRESS) exp_count = exp_count + 8'd1;
    e.kind  = kind;
    e.cyc   = at;
    e.count = exp_count;
    exp_q.push_back(e);
  endtask

  // A pulse is required exactly when the queue head names this kind and cycle;
  // otherwise the pulse must be low.
  task automatic observe(input ev_e kind, input logic pulse, input string name);
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc && exp_q[0].kind == kind) begin
      check({name, "_expected"}, {31'd0, pulse}, 32'd1);
      if (kind == EV_PRESS)
        check("press_count_at_press", {24'd0, press_count}, {24'd0, exp_q[0].count});
      void'(exp_q.pop_front());
    end else begin
      check({name, "_unexpected"}, {31'd0, pulse}, 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    observe(EV_PRESS,   press_pulse,   "press_pulse");
    observe(EV_RELEASE, release_pulse, "release_pulse");
    observe(EV_LONG,    long_pulse,    "long_pulse");
  endtask

  task automatic apply_seg(input vec_t v);
    btn_in = v.btn;
    if (v.exp_press)   expect_ev(EV_PRESS,   cyc + LAT);
    if (v.exp_long)    expect_ev(EV_LONG,    cyc + LAT + LC);
    if (v.exp_release) expect_ev(EV_RELEASE, cyc + LAT);
    repeat (v.cycles) tick();
    check("seg_level", {31'd0, btn_level}, {31'd0, v.exp_level});
    check("seg_count", {24'd0, press_count}, {24'd0, exp_count});
  endtask

  initial begin
    //            btn   cyc press rel  long level
    vecs[0] = '{1'b1, 50, 1'b0, 1'b0, 1'b0, 1'b0};  // idle after reset
    vecs[1] = '{1'b0, 12, 1'b1, 1'b0, 1'b0, 1'b1};  // clean press
    vecs[2] = '{1'b1, 12, 1'b0, 1'b1, 1'b0, 1'b0};  // clean release
    vecs[3] = '{1'b0,  3, 1'b0, 1'b0, 1'b0, 1'b0};  // bounce: low 3
    vecs[4] = '{1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0};  //         high 1
    vecs[5] = '{1'b0,  3, 1'b0, 1'b0, 1'b0, 1'b0};  //         low 3
    vecs[6] = '{1'b1, 12, 1'b0, 1'b0, 1'b0, 1'b0};  //         settle high
    vecs[7] = '{1'b0, 40, 1'b1, 1'b0, 1'b1, 1'b1};  // long hold
    vecs[8] = '{1'b1, 12, 1'b0, 1'b1, 1'b0, 1'b0};  // release after long

    // Reset with the button released.
    rst_n  = 1'b0;
    btn_in = 1'b1;
    repeat (3) tick();
    check("reset_level", {31'd0, btn_level}, 32'd0);
    check("reset_count", {24'd0, press_count}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) apply_seg(vecs[i]);

    // Press until the counter wraps back to zero.
    while (exp_count != 8'd0) begin
      apply_seg('{1'b0, 8, 1'b1, 1'b0, 1'b0, 1'b1});
      apply_seg('{1'b1, 8, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    check("count_wrapped", {24'd0, press_count}, 32'd0);

    // Release lands on the edge where the long threshold would fire.
    btn_in = 1'b0;
    expect_ev(EV_PRESS, cyc + LAT);
    repeat (LC) tick();
    btn_in = 1'b1;
    expect_ev(EV_RELEASE, cyc + LAT);
    repeat (12) tick();
    check("race_level", {31'd0, btn_level}, 32'd0);
    check("race_count", {24'd0, press_count}, 32'd1);

    // Asynchronous reset in the middle of a press.
    btn_in = 1'b0;
    expect_ev(EV_PRESS, cyc + LAT);
    repeat (10) tick();
    check("pre_reset_level", {31'd0, btn_level}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_level", {31'd0, btn_level}, 32'd0);
    check("async_reset_count", {24'd0, press_count}, 32'd0);
    check("async_reset_pulses", {29'd0, press_pulse, release_pulse, long_pulse}, 32'd0);
    exp_count = 8'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    expect_ev(EV_PRESS, cyc + LAT);
    repeat (10) tick();
    check("post_reset_level", {31'd0, btn_level}, 32'd1);
    check("post_reset_count", {24'd0, press_count}, 32'd1);
    apply_seg('{1'b1, 12, 1'b0, 1'b1, 1'b0, 1'b0});

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
